// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: walks IF/ID/EX/MEM/WB and drives datapath enables.
// Optional MC_MEM_READY_EN adds a mem_ready input that stalls IF and MEM.
module multicycle_control_fsm #(
  parameter int HALT_CODE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [31:0] rf17,
  input  logic        alu_bcond,
`ifdef MC_MEM_READY_EN
  input  logic        mem_ready,
`endif
  output logic        pc_write,
  output logic        pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        is_halted,
  output logic [2:0]  state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   halt_hit;
  logic   known_op;

`ifdef MC_MEM_READY_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign halt_hit = (rf17 == 32'(HALT_CODE));
  assign known_op = (opcode == OP_R)      || (opcode == OP_I)     ||
                    (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                    (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                    (opcode == OP_JALR);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = mem_rdy ? S_ID : S_IF;
      S_ID: begin
        if (opcode == OP_ECALL) state_d = halt_hit ? S_HALT : S_IF;
        else if (known_op)      state_d = S_EX;
        else                    state_d = S_WB;
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:   state_d = S_MEM;
          OP_BRANCH:           state_d = alu_bcond ? S_IF : S_WB;
          default:             state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (!mem_rdy)               state_d = S_MEM;
        else if (opcode == OP_LOAD) state_d = S_WB;
        else                        state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Outputs are forced low during reset so no write fires in the cycle that aborts an instruction.
  always_comb begin
    pc_write  = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = '0;
    alu_src_a = 1'b0;
    alu_src_b = '0;
    alu_op    = '0;
    is_halted = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_rdy;
        end
        S_ID: begin
          alu_src_b = 2'b10;
          if (opcode == OP_ECALL && !halt_hit) begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
          end
        end
        S_EX: begin
          case (opcode)
            OP_R: begin
              alu_src_a = 1'b1;
              alu_op    = 2'b10;
            end
            OP_I: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = 2'b10;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
            end
            OP_BRANCH: begin
              alu_src_a = 1'b1;
              alu_op    = 2'b01;
              pc_write  = alu_bcond;
              pc_source = alu_bcond;
            end
            OP_JAL: begin
              alu_src_b = 2'b01;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              pc_write  = 1'b1;
              pc_source = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (opcode == OP_LOAD) begin
            mem_read = 1'b1;
          end else if (opcode == OP_STORE) begin
            mem_write = mem_rdy;
            pc_write  = mem_rdy;
            alu_src_b = 2'b01;
          end
        end
        S_WB: begin
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          case (opcode)
            OP_R, OP_I: reg_write = 1'b1;
            OP_LOAD: begin
              reg_write = 1'b1;
              wb_sel    = 2'b01;
            end
            OP_JALR: begin
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              pc_source = 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT:  is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction class expands to its expected per-cycle control sequence.
// Build with +define+MC_MEM_READY_EN to also exercise IF stalls.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [31:0] rf17;
  logic        alu_bcond;
`ifdef MC_MEM_READY_EN
  logic        mem_ready;
`endif
  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  wb_sel, alu_src_b, alu_op;
  logic        alu_src_a, is_halted;
  logic [2:0]  state;

  multicycle_control_fsm #(.HALT_CODE(10)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rf17(rf17), .alu_bcond(alu_bcond),
`ifdef MC_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_halted(is_halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, pcs, iod, mr, mw, irw, rw;
    logic [1:0] wbs;
    logic       sa;
    logic [1:0] sb, aop;
    logic       hlt;
  } ctl_t;

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_ECALL = 7, C_NOP = 8, C_HALT = 9;

  int   checks = 0;
  int   errors = 0;
  ctl_t exp_q[$];

  function automatic ctl_t observed();
    ctl_t o;
    o.st = state; o.pcw = pc_write; o.pcs = pc_source; o.iod = i_or_d; o.mr = mem_read;
    o.mw = mem_write; o.irw = ir_write; o.rw = reg_write; o.wbs = wb_sel; o.sa = alu_src_a;
    o.sb = alu_src_b; o.aop = alu_op; o.hlt = is_halted;
    return o;
  endfunction

  function automatic logic [6:0] opcode_of(input int cls);
    logic [6:0] nops [4];
    nops = '{7'b0110111, 7'b0010111, 7'b0001111, 7'b1111111};
    case (cls)
      C_R:             return 7'b0110011;
      C_I:             return 7'b0010011;
      C_LOAD:          return 7'b0000011;
      C_STORE:         return 7'b0100011;
      C_BR:            return 7'b1100011;
      C_JAL:           return 7'b1101111;
      C_JALR:          return 7'b1100111;
      C_ECALL, C_HALT: return 7'b1110011;
      default:         return nops[$urandom_range(0, 3)];
    endcase
  endfunction

  function automatic ctl_t ex_step(input logic sa, input logic [1:0] sb, input logic [1:0] aop);
    ctl_t c = '0;
    c.st = 3'd2; c.sa = sa; c.sb = sb; c.aop = aop;
    return c;
  endfunction

  // Writeback always advances the PC; only JALR takes it from ALUOut.
  function automatic ctl_t wb_step(input logic rw, input logic [1:0] wbs, input logic pcs);
    ctl_t c = '0;
    c.st = 3'd4; c.pcw = 1'b1; c.sb = 2'b01; c.rw = rw; c.wbs = wbs; c.pcs = pcs;
    return c;
  endfunction

  task automatic push_instr(input int cls, input logic bc);
    ctl_t c;
    c = '0; c.st = 3'd0; c.mr = 1'b1; c.irw = 1'b1;
    exp_q.push_back(c);
    c = '0; c.st = 3'd1; c.sb = 2'b10;
    if (cls == C_HALT) begin
      exp_q.push_back(c);
      c = '0; c.st = 3'd5; c.hlt = 1'b1;
      repeat (20) exp_q.push_back(c);
      return;
    end
    if (cls == C_ECALL) begin
      c.sb = 2'b01; c.pcw = 1'b1;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    case (cls)
      C_R:    begin exp_q.push_back(ex_step(1, 2'b00, 2'b10)); exp_q.push_back(wb_step(1, 2'b00, 0)); end
      C_I:    begin exp_q.push_back(ex_step(1, 2'b10, 2'b10)); exp_q.push_back(wb_step(1, 2'b00, 0)); end
      C_LOAD: begin
        exp_q.push_back(ex_step(1, 2'b10, 2'b00));
        c = '0; c.st = 3'd3; c.iod = 1'b1; c.mr = 1'b1;
        exp_q.push_back(c);
        exp_q.push_back(wb_step(1, 2'b01, 0));
      end
      C_STORE: begin
        exp_q.push_back(ex_step(1, 2'b10, 2'b00));
        c = '0; c.st = 3'd3; c.iod = 1'b1; c.mw = 1'b1; c.pcw = 1'b1; c.sb = 2'b01;
        exp_q.push_back(c);
      end
      C_BR: begin
        c = ex_step(1, 2'b00, 2'b01); c.pcw = bc; c.pcs = bc;
        exp_q.push_back(c);
        if (!bc) exp_q.push_back(wb_step(0, 2'b00, 0));
      end
      C_JAL: begin
        c = ex_step(0, 2'b01, 2'b00); c.rw = 1'b1; c.wbs = 2'b10; c.pcw = 1'b1; c.pcs = 1'b1;
        exp_q.push_back(c);
      end
      C_JALR: begin exp_q.push_back(ex_step(1, 2'b10, 2'b00)); exp_q.push_back(wb_step(1, 2'b10, 1)); end
      default: exp_q.push_back(wb_step(0, 2'b00, 0));
    endcase
  endtask

  task automatic check(input ctl_t e, input string tag);
    ctl_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_reset_cycle(input string tag);
    ctl_t o;
    o = observed();
    o.st = '0;
    checks++;
    assert (o === ctl_t'('0)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, ctl_t'('0));
    end
  endtask

  // Runs up to n expected cycles (n < 0: all), sampling on the falling edge; returns pc_write count.
  task automatic run_steps(input int n, input string tag, output int pcw_n);
    ctl_t e;
    int   k = 0;
    pcw_n = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check(e, tag);
      if (pc_write === 1'b1) pcw_n++;
      checks++;
      assert (!(reg_write === 1'b1 && mem_write === 1'b1)) else begin
        errors++;
        $error("FAIL %s_rw_mw observed=%b%b expected=not both", tag, reg_write, mem_write);
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_reset(input int cycles, input string tag);
    reset = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      check_reset_cycle(tag);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input int cls, input int stall, input string tag);
    int   pcw_n;
    logic bc;
    ctl_t c;
    bc        = 1'($urandom_range(0, 1));
    opcode    = opcode_of(cls);
    alu_bcond = bc;
    if (cls == C_HALT)      rf17 = 32'd10;
    else if (cls == C_ECALL) rf17 = 32'($urandom_range(11, 40));
    else                     rf17 = 32'($urandom_range(0, 15));
`ifdef MC_MEM_READY_EN
    if (stall > 0) begin
      mem_ready = 1'b0;
      c = '0; c.st = 3'd0; c.mr = 1'b1;
      repeat (stall) exp_q.push_back(c);
      run_steps(-1, {tag, "_stall"}, pcw_n);
      mem_ready = 1'b1;
    end
`else
    c = '0;
    if (stall > 0) c.st = 3'd0;
`endif
    push_instr(cls, bc);
    run_steps(-1, tag, pcw_n);
    if (cls != C_HALT) begin
      checks++;
      assert (pcw_n == 1) else begin
        errors++;
        $error("FAIL %s_pc_writes observed=%0d expected=1", tag, pcw_n);
      end
    end
  endtask

  initial begin
    int pcw_n;
    reset     = 1'b1;
    opcode    = 7'b0010011;
    rf17      = '0;
    alu_bcond = 1'b0;
`ifdef MC_MEM_READY_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk); #1;
    do_reset(2, "reset");

    run_instr(C_R, 0, "add");
    run_instr(C_LOAD, 0, "lw");
    run_instr(C_STORE, 0, "sw");
    run_instr(C_JAL, 0, "jal");
    run_instr(C_JALR, 0, "jalr");
    run_instr(C_ECALL, 0, "ecall_cont");
    run_instr(C_NOP, 0, "nop");
`ifdef MC_MEM_READY_EN
    run_instr(C_R, 3, "if_stall");
`endif

    for (int i = 0; i < 150; i++) begin
      run_instr($urandom_range(0, 8), 0, "rand");
    end

    opcode = opcode_of(C_STORE);
    push_instr(C_STORE, 1'b0);
    run_steps(3, "sw_abort", pcw_n);
    exp_q.delete();
    do_reset(1, "reset_mid_mem");
    run_instr(C_BR, 0, "after_abort");

    run_instr(C_HALT, 0, "halt");
    do_reset(2, "reset_from_halt");
    run_instr(C_I, 0, "after_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
